// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if
//   Groups the PC-register, instruction-memory and decode-stage signals of the
//   fetch sequencer into one bundle.
//   master : the sequencer (drives pc_next, imem_req, fetch_valid, fetch_pc,
//            flush and, with PC_FETCH_ALIGN_CHECK_EN, trap/trap_addr)
//   slave  : the surrounding pipeline (drives pc_cur, imem_ready, stall,
//            branch_taken/branch_target, jump/jump_target)
//   Optional: `define PC_FETCH_ALIGN_CHECK_EN adds trap and trap_addr.
interface pc_fetch_sequencer_if;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic        trap;
  logic [31:0] trap_addr;

  modport master (
    input  pc_cur, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target,
    output pc_next, imem_req, fetch_valid, fetch_pc, flush, trap, trap_addr
  );

  modport slave (
    output pc_cur, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target,
    input  pc_next, imem_req, fetch_valid, fetch_pc, flush, trap, trap_addr
  );
`else
  modport master (
    input  pc_cur, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target,
    output pc_next, imem_req, fetch_valid, fetch_pc, flush
  );

  modport slave (
    output pc_cur, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target,
    input  pc_next, imem_req, fetch_valid, fetch_pc, flush
  );
`endif
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the next-address input of an enable-less, reset-less PC register and
//   issues instruction fetch requests at pc_cur. Chooses between reset vector,
//   hold, sequential increment, taken branch and jump; a control transfer
//   produces a one-cycle flush pulse followed by a one-cycle redirect bubble.
// Ports:
//   clk  - system clock, all state changes on posedge
//   rst  - synchronous active-high reset
//   bus  - pc_fetch_sequencer_if.master (pc_cur/pc_next, imem_req/imem_ready,
//          stall, branch/jump controls, fetch_valid/fetch_pc, flush)
// Optional: `define PC_FETCH_ALIGN_CHECK_EN redirects misaligned jump/branch
//   targets to TRAP_VECTOR and reports them on trap/trap_addr.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned INSTR_BYTES  = 4
`ifdef PC_FETCH_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  pc_fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    FETCH    = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_nx;

  logic [31:0] pc_next;
  logic        imem_req;
  logic        fetch_valid;
  logic        flush;
  logic        redirect;
  logic [31:0] redir_target;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic        trap;
  logic [31:0] trap_addr;
`endif

  // Jump outranks a simultaneous taken branch.
  assign redirect     = bus.jump | bus.branch_taken;
  assign redir_target = bus.jump ? bus.jump_target : bus.branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state_q;
    pc_next     = bus.pc_cur;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    trap        = 1'b0;
    trap_addr   = '0;
`endif
    if (rst) begin
      // Reset overrides whatever the state register holds, so an in-flight
      // redirect or fetch is simply dropped.
      state_nx = BOOT;
      pc_next  = RESET_VECTOR;
    end else begin
      case (state_q)
        BOOT: begin
          pc_next  = RESET_VECTOR;
          state_nx = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          if (redirect) begin
            // Any fetch returning this cycle belongs to the squashed path.
            flush    = 1'b1;
            pc_next  = redir_target;
            state_nx = REDIRECT;
`ifdef PC_FETCH_ALIGN_CHECK_EN
            if (redir_target[1:0] != 2'b00) begin
              pc_next   = TRAP_VECTOR;
              trap      = 1'b1;
              trap_addr = redir_target;
            end
`endif
          end else if (bus.stall || !bus.imem_ready) begin
            pc_next = bus.pc_cur;
          end else begin
            fetch_valid = 1'b1;
            pc_next     = bus.pc_cur + 32'(INSTR_BYTES);
          end
        end
        REDIRECT: begin
          // Branch/jump inputs here come from squashed instructions.
          pc_next  = bus.pc_cur;
          state_nx = FETCH;
        end
        default: begin
          state_nx = BOOT;
          pc_next  = RESET_VECTOR;
        end
      endcase
    end
  end

  assign bus.pc_next     = pc_next;
  assign bus.imem_req    = imem_req;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_pc    = bus.pc_cur;
  assign bus.flush       = flush;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign bus.trap        = trap;
  assign bus.trap_addr   = trap_addr;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
//   Directed-vector bench for pc_fetch_sequencer. Models the external PC
//   register (captures pc_next every posedge) and checks combinational outputs
//   mid-cycle against hand-computed values.
//   Optional: `define PC_FETCH_ALIGN_CHECK_EN exercises the trap outputs.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_reg = 32'hDEAD_BEEF;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External PC register: no enable, no reset.
  always_ff @(posedge clk) pc_reg <= bus.pc_next;
  assign bus.pc_cur = pc_reg;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs at the negedge, then settle before checking.
  task automatic cyc(input logic r, input logic s, input logic rdy,
                     input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt);
    @(negedge clk);
    rst               = r;
    bus.stall         = s;
    bus.imem_ready    = rdy;
    bus.branch_taken  = b;
    bus.branch_target = bt;
    bus.jump          = j;
    bus.jump_target   = jt;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic fv,
                            input logic fl, input logic [31:0] pcn);
    check({tag, ".imem_req"},    32'(bus.imem_req),    32'(req));
    check({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(fv));
    check({tag, ".flush"},       32'(bus.flush),       32'(fl));
    check({tag, ".pc_next"},     bus.pc_next,          pcn);
  endtask

  initial begin
    bus.stall         = 1'b0;
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;

    // Reset for two cycles
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 1, 0, 0, 0, 0);
      expect_out("reset", 0, 0, 0, RV);
`ifdef PC_FETCH_ALIGN_CHECK_EN
      check("reset.trap",      32'(bus.trap), 32'd0);
      check("reset.trap_addr", bus.trap_addr, 32'd0);
`endif
    end

    // BOOT bubble, then sequential fetch
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("boot", 0, 0, 0, RV);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("fetch0", 1, 1, 0, 32'h4);
    check("fetch0.fetch_pc", bus.fetch_pc, 32'h0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("fetch4", 1, 1, 0, 32'h8);
    check("fetch4.fetch_pc", bus.fetch_pc, 32'h4);

    // Hold at 8: stall 3 cycles, then memory wait 2 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0, 0, 0);
      expect_out("stall", 1, 0, 0, 32'h8);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      expect_out("wait", 1, 0, 0, 32'h8);
    end
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("resume8", 1, 1, 0, 32'hC);
    check("resume8.fetch_pc", bus.fetch_pc, 32'h8);

    // Branch at C to 40, squashing a ready fetch
    cyc(0, 0, 1, 1, 32'h40, 0, 0);
    expect_out("branch", 1, 0, 1, 32'h40);
    // Branch during REDIRECT is ignored
    cyc(0, 0, 1, 1, 32'h99, 0, 0);
    expect_out("redir_br", 0, 0, 0, 32'h40);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("fetch40", 1, 1, 0, 32'h44);
    check("fetch40.fetch_pc", bus.fetch_pc, 32'h40);

    // Jump and branch together: jump wins
    cyc(0, 0, 1, 1, 32'h40, 1, 32'h80);
    expect_out("collide", 1, 0, 1, 32'h80);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("redir80", 0, 0, 0, 32'h80);

    // Jump to top of address space, then wrap on increment
    cyc(0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    expect_out("jtop", 1, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("redirtop", 0, 0, 0, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("wrap", 1, 1, 0, 32'h0);
    check("wrap.fetch_pc", bus.fetch_pc, 32'hFFFF_FFFC);

    // Reset asserted during a REDIRECT cycle
    cyc(0, 0, 1, 0, 0, 1, 32'h20);
    expect_out("j20", 1, 0, 1, 32'h20);
    cyc(1, 0, 1, 1, 32'h60, 1, 32'h70);
    expect_out("rst_redir", 0, 0, 0, RV);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("reboot", 0, 0, 0, RV);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("refetch0", 1, 1, 0, 32'h4);

    // Misaligned jump target at PC=4
    cyc(0, 0, 1, 0, 0, 1, 32'h42);
`ifdef PC_FETCH_ALIGN_CHECK_EN
    expect_out("jmis", 1, 0, 1, TV);
    check("jmis.trap",      32'(bus.trap), 32'd1);
    check("jmis.trap_addr", bus.trap_addr, 32'h42);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("redirtrap", 0, 0, 0, TV);
    check("redirtrap.trap", 32'(bus.trap), 32'd0);
`else
    expect_out("jmis", 1, 0, 1, 32'h42);
    cyc(0, 0, 1, 0, 0, 0, 0);
    expect_out("redirmis", 0, 0, 0, 32'h42);
    check("redirmis.tv_unused", bus.pc_cur ^ TV, 32'h42 ^ TV);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
